// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and defaults for the pipeline stages
//
// Purpose : occupancy encoding and default payload width reused by every
//           pipeline stage (skid register, dff entries, interface).
// Contents: PIPE_WIDTH  default payload width
//           occ_t       EMPTY / ONE / FULL occupancy of a two-entry stage
package pipe_pkg;

  localparam int PIPE_WIDTH = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// rtl/pipe_skid_reg_if.sv - handshake bundle for the skid register stage
//
// Purpose : groups the upstream and downstream valid/ready/data signals and
//           the flush strobe of one pipe_skid_reg.
// Ports   : flush                         synchronous clear of the stage
//           in_valid / in_ready / in_data upstream handshake
//           out_valid / out_ready / out_data downstream handshake
// Modports: slave  - the stage itself
//           master - the environment driving the stage
interface pipe_skid_reg_if
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH
);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pipe_dff_en.sv
// rtl/pipe_dff_en.sv - one storage entry with sync reset, clear and enable
//
// Purpose : WIDTH-bit register; rst or clr load RESET_VAL, otherwise en loads d.
// Ports   : clk  clock
//           rst  synchronous active-high reset
//           clr  synchronous clear to RESET_VAL
//           en   load enable
//           d    next value
//           q    stored value
module pipe_dff_en
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = PIPE_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - two-entry skid register with registered ready
//
// Purpose : fully registered pipeline stage; in_ready and out_data/out_valid
//           come straight from flops so the stage cuts both the data and the
//           ready timing paths. Optional stall counter under PIPE_SKID_PERF_EN.
// Ports   : clk        clock
//           rst        synchronous active-high reset
//           bus        pipe_skid_reg_if.slave (flush, in_*, out_*)
//           stall_cnt  cycles with out_valid && !out_ready, saturating
//                      (present only when PIPE_SKID_PERF_EN is defined)
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = PIPE_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_skid_reg_if.slave       bus
`ifdef PIPE_SKID_PERF_EN
  ,
  output logic [31:0]          stall_cnt
`endif
);

  occ_t             state;
  occ_t             state_nxt;
  logic             in_ready_q;
  logic             accept;
  logic             xfer;
  logic             main_en;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  assign accept = bus.in_valid && in_ready_q;
  assign xfer   = (state != EMPTY) && bus.out_ready;

  // In FULL the main register refills from the skid entry; otherwise the
  // only source for main is the incoming word.
  assign main_d = (state == FULL) ? skid_q : bus.in_data;

  always_comb begin
    state_nxt = state;
    main_en   = 1'b0;
    skid_en   = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          main_en   = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (accept && xfer) begin
          main_en = 1'b1;
        end else if (accept) begin
          skid_en   = 1'b1;
          state_nxt = FULL;
        end else if (xfer) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (xfer) begin
          main_en   = 1'b1;
          state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // in_ready is computed from the next occupancy and registered, so it never
  // depends combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != FULL);
    end
  end

  pipe_dff_en #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
    .clk (clk),
    .rst (rst),
    .clr (bus.flush),
    .en  (main_en),
    .d   (main_d),
    .q   (main_q)
  );

  pipe_dff_en #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
    .clk (clk),
    .rst (rst),
    .clr (bus.flush),
    .en  (skid_en),
    .d   (bus.in_data),
    .q   (skid_q)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state != EMPTY);
  assign bus.out_data  = main_q;

`ifdef PIPE_SKID_PERF_EN
  // Survives flush on purpose: it measures back-pressure across the run.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
    end else if (bus.out_valid && !bus.out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - self-checking bench for pipe_skid_reg
module tb_pipe_skid_reg;
  import pipe_pkg::*;

  localparam int         W  = 32;
  localparam logic [W-1:0] RV = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_skid_reg_if #(.WIDTH(W)) bus ();

`ifdef PIPE_SKID_PERF_EN
  logic [31:0] stall_cnt;
`endif

  pipe_skid_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef PIPE_SKID_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] main_exp;
  logic [31:0]  exp_stall;
  logic         acc_last;
  logic [W-1:0] pay;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".in_ready"},  W'(bus.in_ready),  W'(q.size() != 2));
    chk({tag, ".out_valid"}, W'(bus.out_valid), W'(q.size() != 0));
    chk({tag, ".out_data"},  bus.out_data, main_exp);
`ifdef PIPE_SKID_PERF_EN
    chk({tag, ".stall_cnt"}, stall_cnt, exp_stall);
`endif
  endtask

  // Check the current state, advance the model by one edge, then clock the DUT.
  task automatic cycle(input string tag);
    logic xf;
    check_outputs(tag);
    acc_last = bus.in_valid && (q.size() < 2);
    xf       = bus.out_ready && (q.size() > 0);
    if (rst) begin
      exp_stall = 32'd0;
    end else if ((q.size() > 0) && !bus.out_ready && (exp_stall != 32'hFFFF_FFFF)) begin
      exp_stall = exp_stall + 32'd1;
    end
    if (rst || bus.flush) begin
      q.delete();
      main_exp = RV;
      acc_last = 1'b0;
    end else begin
      if (xf) void'(q.pop_front());
      if (acc_last) q.push_back(bus.in_data);
      if (q.size() > 0) main_exp = q[0];
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    main_exp      = RV;
    exp_stall     = 32'd0;
    acc_last      = 1'b0;
    pay           = '0;

    // reset: first edge brings the DUT out of X, second is checked
    @(posedge clk);
    #1;
    cycle("rst");
    rst = 1'b0;

    // single word, one-cycle latency
    bus.in_valid = 1'b1; bus.in_data = 32'hA5A5_A5A5; bus.out_ready = 1'b1;
    cycle("a5_push");
    bus.in_valid = 1'b0;
    cycle("a5_out");
    cycle("a5_empty");

    // back-pressure fills both entries, then drains in order
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 32'h1;
    cycle("bp_push1");
    bus.in_data = 32'h2;
    cycle("bp_push2");
    bus.in_valid = 1'b0;
    cycle("bp_full_hold");
    cycle("bp_full_hold2");
    bus.out_ready = 1'b1;
    cycle("bp_drain1");
    cycle("bp_drain2");
    cycle("bp_empty");

    // flush while FULL with accept and output transfer offered
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    bus.in_data = 32'h3; cycle("fl_push3");
    bus.in_data = 32'h4; cycle("fl_push4");
    bus.flush = 1'b1; bus.in_data = 32'h5; bus.out_ready = 1'b1;
    cycle("fl_flush");
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    cycle("fl_after");
    cycle("fl_after2");

    // reset wins over flush and transfers while FULL
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    bus.in_data = 32'h6; cycle("rf_push6");
    bus.in_data = 32'h7; cycle("rf_push7");
    rst = 1'b1; bus.flush = 1'b1; bus.in_data = 32'h8; bus.out_ready = 1'b1;
    cycle("rf_rst");
    rst = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0;
    cycle("rf_after");

    // seven stall cycles, flush, then reset
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = 32'h9;
    cycle("st_push");
    bus.in_valid = 1'b0;
    for (int i = 0; i < 7; i++) cycle("st_stall");
    bus.flush = 1'b1; bus.out_ready = 1'b1;
    cycle("st_flush");
    bus.flush = 1'b0;
    cycle("st_after_flush");
    rst = 1'b1;
    cycle("st_rst");
    rst = 1'b0;
    cycle("st_after_rst");

    // random traffic with incrementing payload
    for (int i = 0; i < 10000; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_data   = pay;
      cycle("rand");
      if (acc_last) pay = pay + 1'b1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cycle("rand_drain1");
    cycle("rand_drain2");
    cycle("rand_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits (legal 1..256).
REQ-002 Parameter RESET_VAL, default 0, WIDTH-bit value loaded into both data registers on reset or flush.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 flush  input  1  synchronous clear of all buffered entries.
REQ-006 in_valid  input  1  upstream offers in_data.
REQ-007 in_ready  output  1  block can accept; transfer when in_valid && in_ready.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 out_valid  output  1  out_data holds a valid entry.
REQ-010 out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
REQ-011 out_data  output  WIDTH  payload at the head of the buffer.
REQ-012 stall_cnt  output  32  stall-cycle counter; present only with PIPE_SKID_PERF_EN.

Function
REQ-013 Storage SHALL be two entries: main register (drives out_data) and skid register; occupancy state EMPTY, ONE or FULL.
REQ-014 in_ready SHALL be a registered signal equal to (state != FULL), with no combinational path from out_ready.
REQ-015 out_valid SHALL equal (state != EMPTY); out_data SHALL equal the main register, with no combinational path from in_data.
REQ-016 Latency SHALL be one cycle: data accepted at edge N is visible on out_data after edge N.
REQ-017 EMPTY: an accept loads main -> ONE; no accept -> stay.
REQ-018 ONE: accept && output transfer -> main loads in_data, stay ONE; accept only -> skid loads in_data, FULL; output transfer only -> EMPTY; neither -> stay.
REQ-019 FULL: output transfer -> main loads skid, ONE; otherwise stay. No accept is possible in FULL.
REQ-020 While out_valid && !out_ready, out_data SHALL hold stable.
REQ-021 Order SHALL be strictly FIFO; no entry is duplicated or dropped except by flush or reset.
REQ-022 flush SHALL force state EMPTY and both data registers to RESET_VAL at the next edge; any accept or output transfer in the flush cycle is discarded.
REQ-023 Data registers SHALL load only on the events above and otherwise hold.

Reset
REQ-024 rst SHALL set state EMPTY, out_valid 0, in_ready 1, out_data RESET_VAL, skid RESET_VAL and stall_cnt 0 at the next edge.
REQ-025 rst SHALL take priority over flush and over all transfers, including mid-operation in FULL.

Configuration
REQ-026 Macro PIPE_SKID_PERF_EN defined: stall_cnt increments on every cycle with out_valid && !out_ready and saturates at 0xFFFFFFFF.
REQ-027 With PIPE_SKID_PERF_EN defined, stall_cnt SHALL be cleared by rst only, not by flush.
REQ-028 Macro PIPE_SKID_PERF_EN undefined: the stall_cnt port and its logic are absent; all other behaviour is identical.

Structure
REQ-029 The occupancy enum (EMPTY, ONE, FULL) and default WIDTH SHALL live in shared package pipe_pkg for reuse by the pipeline stages.
REQ-030 A sub-module is natural: the per-entry register pipe_dff_en (WIDTH, RESET_VAL, synchronous rst, clear, enable), instantiated for main and skid.
REQ-031 Total RTL SHALL be roughly 120-250 lines; no memories and no latches.

Verification
REQ-032 Scenario: rst high 2 cycles, then in_valid=1, in_data=0xA5A5A5A5, out_ready=1 -> out_valid=1, out_data=0xA5A5A5A5 one cycle later; in_ready stays 1.
REQ-033 Scenario: out_ready=0, push 0x1 then 0x2 -> in_ready=0 after the 2nd push; out_data holds 0x1. Raise out_ready -> outputs 0x1 then 0x2 on consecutive cycles.
REQ-034 Scenario: FULL, flush=1 with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, out_data=RESET_VAL; neither word appears later.
REQ-035 Scenario: random in_valid/out_ready at 50% for 10000 cycles with an incrementing payload -> scoreboard shows in-order delivery with no loss or duplication, and out_data is stable whenever out_valid && !out_ready.
REQ-036 Scenario (PIPE_SKID_PERF_EN defined): hold out_valid=1, out_ready=0 for 7 cycles, then flush -> stall_cnt=7 and stays 7 after flush; rst -> 0.
